// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode: a circular buffer that
// accepts up to two instructions per cycle and presents the two oldest entries.
module inst_queue #(
  parameter int DEPTH = 8  // power of two, >= 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_A,
  input  logic                     in_valid_B,
  input  logic [31:0]              in_instA,
  input  logic [31:0]              in_instB,
  input  logic [31:0]              in_pcA,
  input  logic [31:0]              in_pcB,
  output logic                     in_ready,
  output logic [31:0]              instA,
  output logic [31:0]              instB,
  output logic [31:0]              pcA,
  output logic [31:0]              pcB,
  output logic                     out_valid_A,
  output logic                     out_valid_B,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - 2);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_plus1;
  logic [PTR_W-1:0] tail_plus1;
  logic [1:0]       push_cnt;
  logic [1:0]       pop_cnt;

  assign head_plus1 = head + 1'b1;
  assign tail_plus1 = tail + 1'b1;

  // Readiness looks only at the registered occupancy so fetch never depends on decode
  assign in_ready    = (count <= READY_LIMIT);
  assign out_valid_A = (count != '0);
  assign out_valid_B = (count >= CNT_W'(2));

  always_comb begin
    push_cnt = 2'd0;
    pop_cnt  = 2'd0;
    if (in_ready && in_valid_A) begin
      push_cnt = in_valid_B ? 2'd2 : 2'd1;
    end
    if (out_ready) begin
      pop_cnt = {1'b0, out_valid_A} + {1'b0, out_valid_B};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end
  end

  // Entry storage carries no reset; validity is tracked solely by count
  always_ff @(posedge clk) begin
    if (!flush && push_cnt != 2'd0) begin
      inst_mem[tail] <= in_instA;
      pc_mem[tail]   <= in_pcA;
    end
    if (!flush && push_cnt == 2'd2) begin
      inst_mem[tail_plus1] <= in_instB;
      pc_mem[tail_plus1]   <= in_pcB;
    end
  end

  assign instA = out_valid_A ? inst_mem[head]       : NOP_INST;
  assign pcA   = out_valid_A ? pc_mem[head]         : 32'h0;
  assign instB = out_valid_B ? inst_mem[head_plus1] : NOP_INST;
  assign pcB   = out_valid_B ? pc_mem[head_plus1]   : 32'h0;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue, checked against a queue-based
// model of the fetch/decode buffer.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_A, in_valid_B;
  logic [31:0] in_instA, in_instB, in_pcA, in_pcB;
  logic        in_ready;
  logic [31:0] instA, instB, pcA, pcB;
  logic        out_valid_A, out_valid_B;
  logic        out_ready;
  logic        flush;
  logic [3:0]  count;

  int check_count = 0;
  int error_count = 0;

  // Model entries are {pc, inst}; front of the queue is the oldest instruction
  logic [63:0] model_q[$];
  logic [31:0] popped_pcs[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_A(in_valid_A), .in_valid_B(in_valid_B),
    .in_instA(in_instA), .in_instB(in_instB),
    .in_pcA(in_pcA), .in_pcB(in_pcB),
    .in_ready(in_ready),
    .instA(instA), .instB(instB), .pcA(pcA), .pcB(pcB),
    .out_valid_A(out_valid_A), .out_valid_B(out_valid_B),
    .out_ready(out_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    int n = model_q.size();
    checkOutput({tag, ".count"}, 64'(count), 64'(n));
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'((DEPTH - n) >= 2));
    checkOutput({tag, ".valid_A"}, 64'(out_valid_A), 64'(n >= 1));
    checkOutput({tag, ".valid_B"}, 64'(out_valid_B), 64'(n >= 2));
    checkOutput({tag, ".A"}, {pcA, instA}, (n >= 1) ? model_q[0] : {32'h0, NOP_INST});
    checkOutput({tag, ".B"}, {pcB, instB}, (n >= 2) ? model_q[1] : {32'h0, NOP_INST});
  endtask

  // Drives one cycle of inputs, advances the model, then checks after the edge
  task automatic applyStimulus(input string tag, input logic va, input logic vb,
                               input logic [31:0] ia, input logic [31:0] pa,
                               input logic [31:0] ib, input logic [31:0] pb,
                               input logic ordy, input logic fl);
    int n = model_q.size();
    int pops;
    bit rdy = (DEPTH - n) >= 2;
    in_valid_A = va; in_valid_B = vb;
    in_instA = ia; in_pcA = pa; in_instB = ib; in_pcB = pb;
    out_ready = ordy; flush = fl;
    if (fl) begin
      model_q.delete();
    end else begin
      pops = ordy ? ((n >= 2) ? 2 : n) : 0;
      repeat (pops) popped_pcs.push_back(model_q.pop_front() >> 32);
      if (va && rdy) model_q.push_back({pa, ia});
      if (va && vb && rdy) model_q.push_back({pb, ib});
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_A = 1'b0; in_valid_B = 1'b0; out_ready = 1'b0; flush = 1'b0;
    checkState(tag);
  endtask

  task automatic idleFlush();
    applyStimulus("flush", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid_A = 0; in_valid_B = 0; in_instA = 0; in_instB = 0;
    in_pcA = 0; in_pcB = 0; out_ready = 0; flush = 0;
    repeat (2) @(negedge clk);
    checkState("reset");
    rst_n = 1'b0;
    @(negedge clk);

    // First push accepted right after reset, one pair visible next cycle
    applyStimulus("pair_push", 1, 1, 32'h00500093, 32'h0, 32'h00A00113, 32'h4, 0, 0);
    checkOutput("pair_pcB", 64'(pcB), 64'h4);
    checkOutput("pair_count", 64'(count), 64'd2);

    // Fill to DEPTH, then an extra push must be refused
    for (int i = 1; i < 4; i++)
      applyStimulus("fill", 1, 1, 32'h1000 + i, 32'h100 + 8 * i, 32'h2000 + i, 32'h104 + 8 * i, 0, 0);
    checkOutput("full_count", 64'(count), 64'd8);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    applyStimulus("overfill", 1, 0, 32'hDEAD, 32'h999, 32'h0, 32'h0, 0, 0);
    checkOutput("overfill_count", 64'(count), 64'd8);

    // Count 3, simultaneous pair pop and pair push
    idleFlush();
    applyStimulus("c3a", 1, 1, 32'h11, 32'h20, 32'h22, 32'h24, 0, 0);
    applyStimulus("c3b", 1, 0, 32'h33, 32'h28, 32'h0, 32'h0, 0, 0);
    applyStimulus("c3pp", 1, 1, 32'h44, 32'h2C, 32'h55, 32'h30, 1, 0);
    checkOutput("c3pp_count", 64'(count), 64'd3);
    checkOutput("c3pp_pcA", 64'(pcA), 64'h28);
    checkOutput("c3pp_pcB", 64'(pcB), 64'h2C);

    // Single entry drained by decode
    idleFlush();
    applyStimulus("one", 1, 0, 32'h77, 32'h10, 32'h0, 32'h0, 0, 0);
    checkOutput("one_validB", 64'(out_valid_B), 64'd0);
    checkOutput("one_instB", 64'(instB), 64'(NOP_INST));
    applyStimulus("one_pop", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    checkOutput("one_pop_count", 64'(count), 64'd0);

    // Flush beats a same-cycle push from count 5
    applyStimulus("f5a", 1, 1, 32'h1, 32'h40, 32'h2, 32'h44, 0, 0);
    applyStimulus("f5b", 1, 1, 32'h3, 32'h48, 32'h4, 32'h4C, 0, 0);
    applyStimulus("f5c", 1, 0, 32'h5, 32'h50, 32'h0, 32'h0, 0, 0);
    checkOutput("f5_count", 64'(count), 64'd5);
    applyStimulus("f5flush", 1, 1, 32'h6, 32'h54, 32'h7, 32'h58, 0, 1);
    checkOutput("f5flush_validA", 64'(out_valid_A), 64'd0);
    applyStimulus("f5after", 1, 1, 32'h8, 32'h60, 32'h9, 32'h64, 0, 0);
    checkOutput("f5after_pcA", 64'(pcA), 64'h60);

    // Streaming 20 pairs with continuous decode wraps the pointers
    idleFlush();
    popped_pcs.delete();
    for (int i = 0; i < 20; i++)
      applyStimulus("stream", 1, 1, 32'hA000 + i, 32'h1000 + 8 * i, 32'hB000 + i, 32'h1004 + 8 * i, 1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("drain", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    checkOutput("stream_total", 64'(popped_pcs.size()), 64'd40);
    begin
      // Model pop history is compared against the DUT's observed outputs above;
      // here the order itself is checked against the ideal sequential PCs
      int k = 0;
      bit ordered = 1'b1;
      foreach (popped_pcs[i]) begin
        if (popped_pcs[i] != 32'h1000 + 4 * i) ordered = 1'b0;
        k++;
      end
      checkOutput("stream_order", 64'(ordered), 64'd1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc_base = $urandom;
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, pc_base,
                    $urandom, pc_base + 4, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 30) == 0));
    end

    // Asynchronous reset clears the queue without a clock edge
    applyStimulus("pre_rst", 1, 1, 32'h5, 32'h70, 32'h6, 32'h74, 0, 0);
    #2 rst_n = 1'b1;
    #1;
    model_q.delete();
    checkState("async_rst");
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus("post_rst", 1, 0, 32'h99, 32'h80, 32'h0, 32'h0, 0, 0);
    checkOutput("post_rst_pcA", 64'(pcA), 64'h80);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the entry count; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, reset; it is asynchronous and active-high (asserted = 1).
REQ-004 The block SHALL have the ports in_valid_A and in_valid_B, each input, 1 bit, marking the fetch-side slot A/B instruction as valid.
REQ-005 The block SHALL have the ports in_instA and in_instB, each input, 32 bits, giving the fetched instructions in program order, A older.
REQ-006 The block SHALL have the ports in_pcA and in_pcB, each input, 32 bits, giving the PCs of in_instA and in_instB.
REQ-007 The block SHALL have the port in_ready, output, 1 bit, asserted when at least 2 entries are free.
REQ-008 The block SHALL have the ports instA, instB, pcA and pcB, each output, 32 bits, giving the two oldest entries for the decoder.
REQ-009 The block SHALL have the ports out_valid_A and out_valid_B, each output, 1 bit, marking the corresponding output slot as valid.
REQ-010 The block SHALL have the port out_ready, input, 1 bit, meaning the decoder consumes all valid output slots this cycle.
REQ-011 The block SHALL have the port flush, input, 1 bit, which discards all entries (branch/jump redirect, exception).
REQ-012 The block SHALL have the port count, output, clog2(DEPTH)+1 bits, giving the current occupancy.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries {pc[31:0], inst[31:0]} with head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-014 Push count SHALL be: 2 if in_valid_A & in_valid_B & in_ready; 1 if in_valid_A & !in_valid_B & in_ready; else 0.
REQ-015 in_valid_B without in_valid_A SHALL be ignored (no push).
REQ-016 On a push, slot A SHALL be written at tail and slot B at tail+1 (mod DEPTH), and tail SHALL advance by the push count.
REQ-017 The outputs SHALL be show-ahead: instA/pcA = entry[head], instB/pcB = entry[head+1], driven from registers with no combinational path from in_* to the outputs.
REQ-018 out_valid_A SHALL equal count>=1, and out_valid_B SHALL equal count>=2.
REQ-019 When an output slot is not valid, its inst and pc SHALL be driven to 32'h00000013 (NOP) and 32'h0 respectively.
REQ-020 Pop count SHALL be out_ready ? (out_valid_A + out_valid_B) : 0; head SHALL advance by the pop count.
REQ-021 A pushed instruction SHALL first appear on the outputs the cycle after the push (latency 1), including when the queue is empty.
REQ-022 Simultaneous push and pop SHALL both take effect, with count_next = count + push - pop.
REQ-023 in_ready SHALL be computed from the registered count only (DEPTH - count >= 2); it SHALL NOT account for a same-cycle pop.
REQ-024 flush SHALL take priority over push and pop: on the next edge head = tail = 0 and count = 0, and all same-cycle pushes are dropped.
REQ-025 count SHALL never exceed DEPTH or go below 0; no push SHALL occur when in_ready = 0.
REQ-026 Entry contents need no reset; only head, tail and count SHALL be reset.

Reset
REQ-027 While rst_n = 1 (asynchronously), head = tail = count = 0, out_valid_A = out_valid_B = 0, instA = instB = 32'h00000013, pcA = pcB = 0, and in_ready = 1.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-029 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 The bench SHALL cover: empty queue, push A=(0x00500093, pc 0x0) and B=(0x00A00113, pc 0x4), out_ready=0 -> next cycle out_valid_A=out_valid_B=1, pcA=0x0, pcB=0x4, count=2.
REQ-031 The bench SHALL cover: fill the DEPTH=8 queue with 4 pair-pushes, out_ready=0 -> count=8, in_ready=0; a further in_valid_A pulse leaves count at 8.
REQ-032 The bench SHALL cover: count=3, out_ready=1 with a pair push -> count=3 next cycle, and head entries are the 3rd and 4th oldest.
REQ-033 The bench SHALL cover: count=1 (pc 0x10), out_ready=1, no push -> that cycle out_valid_B=0 and instB=0x00000013; next cycle count=0.
REQ-034 The bench SHALL cover: count=5 with flush=1 and a same-cycle pair push -> next cycle count=0, out_valid_A=0, and subsequent pushes start at entry 0.
REQ-035 The bench SHALL cover: pointer wrap-around by streaming 20 sequential pairs with out_ready=1 -> pcA/pcB appear in strictly increasing order by 4, with no loss or duplication.
